mmio_io_hub: RTL and testbench

Parametrised memory-mapped I/O hub between the processor data bus and the game peripherals. Replaces the single sprite flip-flop and the direct keyboard mux with NUM_SPRITES independent sprite registers and a FIFO-buffered keyboard scan-code channel. Adds status, control, overflow and flush functions. Sits beside data_memory; the address decoder routes the bus here when hit=1.

---
 rtl/mmio_io_hub.sv | 158 +++++++++++++++
 tb/tb_mmio_io_hub.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: NUM_SPRITES sprite position registers plus a FIFO-buffered
// keyboard scan-code channel with status, control, sticky overflow and flush.

module mmio_sprite_reg #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge reset)
    if (!reset)  q <= '0;
    else if (we) q <= d;
endmodule

module mmio_io_hub #(
  parameter int                DATA_W      = 32,
  parameter logic [DATA_W-1:0] BASE_ADDR   = 'h0000_0400,
  parameter int                NUM_SPRITES = 4,
  parameter int                SPRITE_W    = 10,
  parameter int                FIFO_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DATA_W-1:0]               bus_addr,
  input  logic [DATA_W-1:0]               bus_wdata,
  input  logic                            bus_we,
  input  logic                            bus_re,
  output logic [DATA_W-1:0]               bus_rdata,
  output logic                            hit,
  input  logic [7:0]                      scan_code,
  input  logic                            scan_ready,
  output logic [NUM_SPRITES*SPRITE_W-1:0] sprite_pos,
  output logic                            key_avail,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [DATA_W-1:0] WIN_BYTES = DATA_W'(16 + 4 * NUM_SPRITES);

  typedef struct packed {
    logic       key_data;
    logic       key_status;
    logic       ctrl;
    logic       sprite;
    logic [3:0] idx;
  } dec_t;

  dec_t              dec;
  logic [DATA_W-1:0] off, wo;

  // Word 3 (offset 0xC) is a hole in the map and does not claim the bus.
  always_comb begin
    dec = '0;
    off = bus_addr - BASE_ADDR;
    wo  = off >> 2;
    if (off < WIN_BYTES) begin
      if (wo == DATA_W'(0))      dec.key_data   = 1'b1;
      else if (wo == DATA_W'(1)) dec.key_status = 1'b1;
      else if (wo == DATA_W'(2)) dec.ctrl       = 1'b1;
      else if (wo >= DATA_W'(4)) begin
        dec.sprite = 1'b1;
        dec.idx    = 4'(wo - DATA_W'(4));
      end
    end
  end

  assign hit = dec.key_data | dec.key_status | dec.ctrl | dec.sprite;

  logic wr, rd;
  assign wr = bus_we & hit;
  assign rd = bus_re & hit;

  // Sprite registers
  for (genvar i = 0; i < NUM_SPRITES; i++) begin : g_spr
    mmio_sprite_reg #(.W(SPRITE_W)) u_spr (
      .clk   (clk),
      .reset (reset),
      .we    (wr & dec.sprite & (dec.idx == 4'(i))),
      .d     (bus_wdata[SPRITE_W-1:0]),
      .q     (sprite_pos[i*SPRITE_W +: SPRITE_W])
    );
  end

  // Scan-code FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          ovf, en, sr_q;
  logic          empty, full, flush, push_req, pop, do_push, ovf_set, ovf_clr;

  assign empty    = (count == '0);
  assign full     = (count == CW'(FIFO_DEPTH));
  assign flush    = wr & dec.ctrl & bus_wdata[1];
  assign push_req = scan_ready & ~sr_q & en;
  assign pop      = rd & dec.key_data & ~empty & ~flush;
  // A same-cycle pop frees the slot, so a push into a full FIFO is accepted then.
  assign do_push  = push_req & (~full | pop) & ~flush;
  assign ovf_set  = push_req & full & ~pop & ~flush;
  assign ovf_clr  = wr & dec.key_status & bus_wdata[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
      en     <= 1'b1;
      sr_q   <= 1'b0;
    end else begin
      sr_q <= scan_ready;
      if (wr & dec.ctrl) en <= bus_wdata[0];
      if (ovf_set)       ovf <= 1'b1;
      else if (ovf_clr)  ovf <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (do_push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)     rd_ptr <= rd_ptr + AW'(1);
        case ({do_push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= scan_code;

  assign key_avail  = ~empty;
  assign fifo_count = count;

  // Read mux; the address decode already implies hit.
  always_comb begin
    bus_rdata = '0;
    if (bus_re) begin
      if (dec.key_data && !empty) bus_rdata = DATA_W'(mem[rd_ptr]);
      if (dec.key_status) begin
        bus_rdata[0]    = ~empty;
        bus_rdata[1]    = ovf;
        bus_rdata[15:8] = 8'(count);
      end
      if (dec.ctrl) bus_rdata[0] = en;
      if (dec.sprite)
        for (int i = 0; i < NUM_SPRITES; i++)
          if (dec.idx == 4'(i)) bus_rdata = DATA_W'(sprite_pos[i*SPRITE_W +: SPRITE_W]);
    end
  end

  logic unused_wdata;
  assign unused_wdata = ^bus_wdata;
endmodule

// File: tb/tb_mmio_io_hub.sv
// Scoreboard bench for mmio_io_hub: driver pushes expected outputs from a queue-based
// reference model, a negedge monitor pops and compares.

module tb_mmio_io_hub;
  localparam logic [31:0] BASE  = 32'h0000_0400;
  localparam int          NS    = 4;
  localparam int          SW    = 10;
  localparam int          DEPTH = 8;

  logic          clk, rst_n;
  logic [31:0]   bus_addr, bus_wdata, bus_rdata;
  logic          bus_we, bus_re, hit;
  logic [7:0]    scan_code;
  logic          scan_ready;
  logic [NS*SW-1:0] sprite_pos;
  logic          key_avail;
  logic [3:0]    fifo_count;

  mmio_io_hub #(.DATA_W(32), .BASE_ADDR(BASE), .NUM_SPRITES(NS), .SPRITE_W(SW),
                .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(rst_n), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_we(bus_we), .bus_re(bus_re), .bus_rdata(bus_rdata), .hit(hit),
    .scan_code(scan_code), .scan_ready(scan_ready), .sprite_pos(sprite_pos),
    .key_avail(key_avail), .fifo_count(fifo_count)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          chk_rd;
    logic [31:0] rdata;
    bit          hit;
    logic [NS*SW-1:0] spos;
    logic [3:0]  cnt;
    bit          avail;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, errors = 0;

  // Reference model state
  logic [7:0] fq[$];
  logic [SW-1:0] spr_m[NS];
  bit en_m, ovf_m, prev_m;

  function automatic bit m_hit(input logic [31:0] a);
    logic [31:0] off = a - BASE;
    return (off < 32'(16 + 4 * NS)) && ((off >> 2) != 3);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    logic [31:0] w = (a - BASE) >> 2;
    logic [31:0] r = 0;
    if (!m_hit(a)) return 0;
    case (w)
      0: r = (fq.size() > 0) ? 32'(fq[0]) : 0;
      1: begin r[0] = (fq.size() != 0); r[1] = ovf_m; r[15:8] = 8'(fq.size()); end
      2: r[0] = en_m;
      default: r = 32'(spr_m[w-4]);
    endcase
    return r;
  endfunction

  task automatic model_reset();
    fq.delete();
    for (int i = 0; i < NS; i++) spr_m[i] = 0;
    en_m = 1; ovf_m = 0; prev_m = 0;
  endtask

  task automatic model_update(input logic [31:0] a, input logic [31:0] d, input bit we,
                              input bit re, input bit sr, input logic [7:0] sc);
    logic [31:0] w = (a - BASE) >> 2;
    bit h = m_hit(a);
    bit push_req = sr && !prev_m && en_m;
    bit pop = re && h && w == 0 && fq.size() > 0;
    bit flush = we && h && w == 2 && d[1];
    bit ovf_new = 0;
    if (flush) fq.delete();
    else begin
      if (pop) void'(fq.pop_front());
      if (push_req) begin
        if (fq.size() < DEPTH) fq.push_back(sc);
        else ovf_new = 1;
      end
    end
    if (we && h && w == 1 && d[1]) ovf_m = 0;
    if (ovf_new) ovf_m = 1;
    if (we && h && w == 2) en_m = d[0];
    if (we && h && w >= 4) spr_m[w-4] = d[SW-1:0];
    prev_m = sr;
  endtask

  // One bus cycle: inputs applied at posedge+1, model advanced at the next posedge.
  task automatic step(input logic [31:0] a, input logic [31:0] d, input bit we,
                      input bit re, input bit sr, input logic [7:0] sc);
    exp_t e;
    bus_addr = a; bus_wdata = d; bus_we = we; bus_re = re;
    scan_ready = sr; scan_code = sc;
    e.chk_rd = re;
    e.rdata  = re ? m_read(a) : 0;
    e.hit    = m_hit(a);
    for (int i = 0; i < NS; i++) e.spos[i*SW +: SW] = spr_m[i];
    e.cnt    = 4'(fq.size());
    e.avail  = (fq.size() != 0);
    exp_q.push_back(e);
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_update(a, d, we, re, sr, sc);
    #1;
  endtask

  task automatic idle();                           step(0, 0, 0, 0, 0, 0); endtask
  task automatic wr(input logic [31:0] a, input logic [31:0] d); step(a, d, 1, 0, 0, 0); endtask
  task automatic rd(input logic [31:0] a);         step(a, 0, 0, 1, 0, 0); endtask
  task automatic push_code(input logic [7:0] c);
    step(0, 0, 0, 0, 1, c);
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_n = 0;
    model_reset();
    idle();
    idle();
    rst_n = 1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("hit", 64'(hit), 64'(mon_e.hit));
      if (mon_e.chk_rd) chk("rdata", 64'(bus_rdata), 64'(mon_e.rdata));
      chk("sprite_pos", 64'(sprite_pos), 64'(mon_e.spos));
      chk("fifo_count", 64'(fifo_count), 64'(mon_e.cnt));
      chk("key_avail", 64'(key_avail), 64'(mon_e.avail));
    end
  end

  logic [31:0] alist[13];
  initial begin
    bit sr_r;
    logic [31:0] a, d, w;
    alist = '{BASE, BASE + 4, BASE + 8, BASE + 32'hC, BASE + 32'h10, BASE + 32'h14,
              BASE + 32'h18, BASE + 32'h1C, BASE + 32'h20, 32'h0, BASE - 4, BASE + 1,
              BASE + 32'h13};
    bus_addr = 0; bus_wdata = 0; bus_we = 0; bus_re = 0; scan_ready = 0; scan_code = 0;
    rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    do_reset();

    // Defaults
    rd(BASE + 8); rd(BASE); rd(BASE + 4);

    // Sprite map
    wr(BASE + 32'h10, 32'h3FF); wr(BASE + 32'h1C, 32'hFFFF_F155);
    wr(BASE + 32'h20, 32'h123); idle();
    rd(BASE + 32'h10); rd(BASE + 32'h1C); rd(BASE + 32'h20);

    // Order and wrap
    push_code(8'h1C); push_code(8'h32); push_code(8'h21);
    rd(BASE); rd(BASE); rd(BASE); rd(BASE); idle();
    for (int i = 0; i < 10; i++) begin
      push_code(8'(8'h40 + i));
      rd(BASE);
    end

    // Full and overflow
    for (int i = 1; i <= 9; i++) push_code(8'(i));
    rd(BASE + 4);
    for (int i = 0; i < 8; i++) rd(BASE);
    rd(BASE + 4); wr(BASE + 4, 32'h2); rd(BASE + 4);

    // Simultaneous push and pop while full
    for (int i = 0; i < 8; i++) push_code(8'(8'h80 + i));
    step(BASE, 0, 0, 1, 1, 8'hAA);
    idle(); rd(BASE + 4);

    // Flush wins over push; enable gating; long pulse
    do_reset();
    for (int i = 0; i < 5; i++) push_code(8'(8'h60 + i));
    step(BASE + 8, 32'h3, 1, 0, 1, 8'h77);
    idle(); rd(BASE + 4);
    wr(BASE + 8, 32'h0); push_code(8'h55); rd(BASE + 4); rd(BASE + 8);
    wr(BASE + 8, 32'h1);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 1, 8'h33);
    idle(); rd(BASE + 4); rd(BASE);

    // Reset discards FIFO contents
    push_code(8'h11); push_code(8'h22);
    do_reset();
    rd(BASE); rd(BASE + 4);

    // Randomised traffic
    sr_r = 0;
    for (int i = 0; i < 800; i++) begin
      a = alist[$urandom_range(0, 12)];
      w = (a - BASE) >> 2;
      d = $urandom;
      if (w == 2) d = {30'b0, 1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 7) != 0)};
      if ($urandom_range(0, 2) == 0) sr_r = ~sr_r;
      step(a, d, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, sr_r, 8'($urandom));
    end
    idle(); idle();

    @(negedge clk); #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
